// File: rtl/csr_unit_mmode.sv
// Machine-mode CSR unit: defined M-mode CSRs, 64-bit counters,
// trap/mret status updates and illegal-access detection.
module csr_unit_mmode #(
  parameter int          CNT_W       = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_op,
  input  logic [31:0] reg_data,
  input  logic [4:0]  zimm,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_valid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] trap_vector,
  output logic [31:0] epc_out,
  output logic        irq_en
);

  localparam logic [2:0] NOTCSR_T = 3'b000;
  localparam logic [2:0] CSRRW_T  = 3'b001;
  localparam logic [2:0] CSRRS_T  = 3'b010;
  localparam logic [2:0] CSRRC_T  = 3'b011;
  localparam logic [2:0] CSRRWI_T = 3'b101;
  localparam logic [2:0] CSRRSI_T = 3'b110;
  localparam logic [2:0] CSRRCI_T = 3'b111;

  localparam logic [31:0] TVEC_RST = MTVEC_RESET & ~32'h3;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRH   = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic             st_mie;
  logic             st_mpie;
  logic [31:0]      mie_q;
  logic [31:0]      mtvec_q;
  logic [31:0]      mscratch_q;
  logic [31:0]      mepc_q;
  logic [31:0]      mcause_q;
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;

  logic             is_csr;
  logic             op_rw;
  logic             op_rs;
  logic             op_rc;
  logic [31:0]      src;
  logic [31:0]      old_val;
  logic             hit;
  logic             wr_req;
  logic             read_only;
  logic             illegal;
  logic             do_write;
  logic [31:0]      wdata;
  logic [31:0]      mstatus_val;
  logic [31:0]      cyc_hi;
  logic [31:0]      ret_hi;
  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] ret_nxt;

  always_comb begin
    is_csr = 1'b1;
    op_rw  = 1'b0;
    op_rs  = 1'b0;
    op_rc  = 1'b0;
    case (csr_op)
      CSRRW_T, CSRRWI_T: op_rw = 1'b1;
      CSRRS_T, CSRRSI_T: op_rs = 1'b1;
      CSRRC_T, CSRRCI_T: op_rc = 1'b1;
      NOTCSR_T:          is_csr = 1'b0;
      default:           is_csr = 1'b0;
    endcase
  end

  assign src = csr_op[2] ? {27'b0, zimm} : reg_data;

  // MPP is hardwired to M-mode; only MIE/MPIE are state
  assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie,
                        3'b0, st_mie, 3'b0};

  assign cyc_hi = 32'(mcycle_q >> 32);
  assign ret_hi = 32'(minstret_q >> 32);

  always_comb begin
    hit     = 1'b1;
    old_val = 32'h0;
    case (csr_addr)
      A_MSTATUS:            old_val = mstatus_val;
      A_MIE:                old_val = mie_q;
      A_MTVEC:              old_val = mtvec_q;
      A_MSCRATCH:           old_val = mscratch_q;
      A_MEPC:               old_val = mepc_q;
      A_MCAUSE:             old_val = mcause_q;
      A_MCYCLE, A_CYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH, A_CYCLEH:  old_val = cyc_hi;
      A_MINSTRET, A_INSTRET: old_val = minstret_q[31:0];
      A_MINSTRH, A_INSTRH:  old_val = ret_hi;
      A_MHARTID:            old_val = HART_ID;
      default:              hit = 1'b0;
    endcase
  end

  assign wr_req    = is_csr & (op_rw | (src != 32'h0));
  assign read_only = (csr_addr[11:10] == 2'b11);
  assign illegal   = is_csr & (~hit | (read_only & wr_req));
  assign do_write  = wr_req & ~illegal & ~trap_valid & ~mret_valid;

  always_comb begin
    wdata = src;
    unique case (1'b1)
      op_rs:   wdata = old_val | src;
      op_rc:   wdata = old_val & ~src;
      default: wdata = src;
    endcase
  end

  assign csr_rdata   = (is_csr & ~illegal) ? old_val : 32'h0;
  assign csr_illegal = illegal;
  assign trap_vector = mtvec_q;
  assign epc_out     = mepc_q;
  assign irq_en      = st_mie;

  // A written half takes the new value and suppresses the increment
  always_comb begin
    cyc_nxt = mcycle_q + CNT_W'(1);
    if (do_write && csr_addr == A_MCYCLE)
      cyc_nxt = {mcycle_q[CNT_W-1:32], wdata};
    else if (do_write && csr_addr == A_MCYCLEH)
      cyc_nxt = {wdata[CNT_W-33:0], mcycle_q[31:0]};
  end

  always_comb begin
    ret_nxt = minstret_q + (instr_retire ? CNT_W'(1) : CNT_W'(0));
    if (do_write && csr_addr == A_MINSTRET)
      ret_nxt = {minstret_q[CNT_W-1:32], wdata};
    else if (do_write && csr_addr == A_MINSTRH)
      ret_nxt = {wdata[CNT_W-33:0], minstret_q[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= cyc_nxt;
      minstret_q <= ret_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= TVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else if (trap_valid) begin
      mepc_q   <= trap_pc & ~32'h3;
      mcause_q <= trap_cause;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else if (mret_valid) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie  <= wdata[3];
          st_mpie <= wdata[7];
        end
        A_MIE:      mie_q      <= wdata;
        A_MTVEC:    mtvec_q    <= wdata & ~32'h3;
        A_MSCRATCH: mscratch_q <= wdata;
        A_MEPC:     mepc_q     <= wdata & ~32'h3;
        A_MCAUSE:   mcause_q   <= wdata;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit_mmode.sv
// Scoreboard bench for csr_unit_mmode: directed cases then
// random traffic against a behavioural CSR model.
module tb_csr_unit_mmode;

  localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
  localparam logic [31:0] HART      = 32'h0000_0007;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] RW  = 3'd1;
  localparam logic [2:0] RS  = 3'd2;
  localparam logic [2:0] RC  = 3'd3;
  localparam logic [2:0] RWI = 3'd5;
  localparam logic [2:0] RSI = 3'd6;
  localparam logic [2:0] RCI = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = 12'h0;
  logic [2:0]  csr_op = 3'd0;
  logic [31:0] reg_data = 32'h0;
  logic [4:0]  zimm = 5'h0;
  logic        instr_retire = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_cause = 32'h0;
  logic        mret_valid = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] trap_vector;
  logic [31:0] epc_out;
  logic        irq_en;

  csr_unit_mmode #(
    .CNT_W(64), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART)
  ) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr),
    .csr_op(csr_op), .reg_data(reg_data), .zimm(zimm),
    .instr_retire(instr_retire), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .trap_vector(trap_vector),
    .epc_out(epc_out), .irq_en(irq_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic [31:0] tvec;
    logic [31:0] epc;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: whole registers, not per-field flops
  bit [31:0] m_status, m_ie, m_tvec, m_scratch, m_epc, m_cause;
  bit [63:0] m_cyc, m_ret;

  function automatic void model_reset();
    m_status  = 32'h0000_1800;
    m_ie      = 0;
    m_tvec    = MTVEC_RST & ~32'h3;
    m_scratch = 0;
    m_epc     = 0;
    m_cause   = 0;
    m_cyc     = 0;
    m_ret     = 0;
  endfunction

  function automatic bit model_read(input bit [11:0] a,
                                    output bit [31:0] v);
    v = 0;
    case (a)
      12'h300: v = m_status;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      12'hF14: v = HART;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit [11:0] a,
                      input bit [2:0] op, input bit [31:0] rd,
                      input bit [4:0] z, input bit ret,
                      input bit tr, input bit [31:0] tpc,
                      input bit [31:0] tc, input bit mr);
    bit [31:0] old, src, nv;
    bit        ok, is_csr, wr, ill;
    bit [63:0] c0, r0;
    exp_t      e;
    @(posedge clk);
    #1;
    rst = r; csr_addr = a; csr_op = op; reg_data = rd;
    zimm = z; instr_retire = ret; trap_valid = tr;
    trap_pc = tpc; trap_cause = tc; mret_valid = mr;
    if (r) model_reset();
    ok     = model_read(a, old);
    is_csr = (op != NOP) && (op != 3'd4);
    src    = op[2] ? {27'b0, z} : rd;
    wr     = is_csr && (op[1:0] == 2'd1 || src != 0);
    ill    = is_csr && (!ok || (a[11:10] == 2'b11 && wr));
    e.rdata = (is_csr && !ill) ? old : 32'h0;
    e.ill   = ill;
    e.tvec  = m_tvec;
    e.epc   = m_epc;
    e.irq   = m_status[3];
    sbq.push_back(e);
    if (!r) begin
      case (op[1:0])
        2'd1:    nv = src;
        2'd2:    nv = old | src;
        default: nv = old & ~src;
      endcase
      c0 = m_cyc;
      r0 = m_ret;
      m_cyc = m_cyc + 1;
      if (ret) m_ret = m_ret + 1;
      if (tr) begin
        m_epc    = tpc & ~32'h3;
        m_cause  = tc;
        m_status = 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
      end else if (mr) begin
        m_status = 32'h1880 | (m_status[7] ? 32'h8 : 32'h0);
      end else if (wr && !ill) begin
        case (a)
          12'h300: m_status = (nv & 32'h88) | 32'h1800;
          12'h304: m_ie = nv;
          12'h305: m_tvec = nv & ~32'h3;
          12'h340: m_scratch = nv;
          12'h341: m_epc = nv & ~32'h3;
          12'h342: m_cause = nv;
          12'hB00: m_cyc = {c0[63:32], nv};
          12'hB80: m_cyc = {nv, c0[31:0]};
          12'hB02: m_ret = {r0[63:32], nv};
          12'hB82: m_ret = {nv, r0[31:0]};
          default: ;
        endcase
      end
    end
  endtask

  task automatic csr(input bit [11:0] a, input bit [2:0] op,
                     input bit [31:0] rd, input bit [4:0] z);
    step(0, a, op, rd, z, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      if (csr_rdata !== e.rdata) begin
        n_err++;
        $display("FAIL rdata a=%h op=%0d got %h exp %h",
                 csr_addr, csr_op, csr_rdata, e.rdata);
      end
      if (csr_illegal !== e.ill) begin
        n_err++;
        $display("FAIL illegal a=%h op=%0d got %b exp %b",
                 csr_addr, csr_op, csr_illegal, e.ill);
      end
      if (trap_vector !== e.tvec) begin
        n_err++;
        $display("FAIL trap_vector got %h exp %h",
                 trap_vector, e.tvec);
      end
      if (epc_out !== e.epc) begin
        n_err++;
        $display("FAIL epc_out got %h exp %h", epc_out, e.epc);
      end
      if (irq_en !== e.irq) begin
        n_err++;
        $display("FAIL irq_en got %b exp %b", irq_en, e.irq);
      end
    end
  end

  bit [11:0] addr_pool [20] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
    12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h301, 12'h000,
    12'hB00, 12'h300
  };
  bit [2:0] op_pool [7] = '{NOP, RW, RS, RC, RWI, RSI, RCI};

  initial begin
    model_reset();
    step(1, 12'hB00, RS, 0, 0, 0, 0, 0, 0, 0);
    step(1, 12'h300, RS, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) csr(12'h0, NOP, 0, 0);
    csr(12'hB00, RS, 0, 0);
    csr(12'h305, RS, 0, 0);
    csr(12'hF14, RS, 0, 0);
    // mstatus writable-field masking
    csr(12'h300, RW, 32'hFFFF_FFFF, 0);
    csr(12'h300, RS, 0, 0);
    csr(12'h300, RCI, 0, 5'd8);
    csr(12'h300, RS, 0, 0);
    // trap then mret
    csr(12'h300, RSI, 0, 5'd8);
    step(0, 12'h0, NOP, 0, 0, 1, 1, 32'h103, 32'd11, 0);
    csr(12'h341, RS, 0, 0);
    csr(12'h342, RS, 0, 0);
    csr(12'h300, RS, 0, 0);
    step(0, 12'h0, NOP, 0, 0, 0, 0, 0, 0, 1);
    csr(12'h300, RS, 0, 0);
    // trap beats a same-cycle write
    step(0, 12'h340, RW, 32'd5, 0, 0, 1, 32'h200, 32'd2, 0);
    csr(12'h340, RS, 0, 0);
    step(0, 12'h340, RW, 32'd9, 0, 0, 0, 0, 0, 1);
    csr(12'h340, RS, 0, 0);
    // read-only and unimplemented addresses
    csr(12'hC00, RW, 32'd1, 0);
    csr(12'hC00, RS, 0, 0);
    csr(12'hC80, RCI, 0, 5'd0);
    csr(12'hC02, RWI, 0, 5'd0);
    csr(12'hC02, RSI, 0, 5'd1);
    csr(12'h7C0, RS, 0, 0);
    csr(12'hF14, RW, 32'd3, 0);
    // counter carry across halves
    csr(12'hB00, RW, 32'hFFFF_FFFF, 0);
    csr(12'hB80, RW, 32'h0, 0);
    csr(12'hB80, RS, 0, 0);
    csr(12'hB80, RS, 0, 0);
    csr(12'hB00, RS, 0, 0);
    step(0, 12'hB02, RW, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
    step(0, 12'hB82, RS, 0, 0, 1, 0, 0, 0, 0);
    csr(12'hB02, RS, 0, 0);
    // reset during a counter write
    step(1, 12'hB00, RW, 32'h123, 0, 1, 0, 0, 0, 0);
    step(1, 12'hB02, RS, 0, 0, 1, 0, 0, 0, 0);
    csr(12'hB00, RS, 0, 0);
    csr(12'hB00, RS, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit [31:0] rd;
      bit [4:0]  z;
      rd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      z  = ($urandom_range(0, 3) == 0) ? 5'h0
                                        : 5'($urandom_range(0, 31));
      step($urandom_range(0, 80) == 0,
           addr_pool[$urandom_range(0, 19)],
           op_pool[$urandom_range(0, 6)], rd, z,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0, $urandom, $urandom,
           $urandom_range(0, 7) == 0);
    end
    csr(12'h0, NOP, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain left %0d exp 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
